// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - mc_state_e : IDLE/BUSY state of the multi-cycle execute timer
//   - STALL_*    : 2-bit stall cause codes driven on the 'stall' output
//   - REG_W      : register-index width (16 architectural registers)
//   - CNT_W      : width of the multi-cycle down-counter and latency values
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_e;

    localparam logic [1:0] STALL_NONE  = 2'b00;
    localparam logic [1:0] STALL_LDUSE = 2'b01;
    localparam logic [1:0] STALL_MULTI = 2'b10;
    localparam logic [1:0] STALL_FLUSH = 2'b11;

    localparam int REG_W = 4;
    localparam int CNT_W = 4;

endpackage

// File: rtl/multicycle_timer.sv
// Occupancy timer for multi-cycle execute operations (MUL/DIV/MOD).
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : launch an operation (only honoured in IDLE)
//   lat        : total execute cycles of the launched operation (>= 2)
//   busy       : timer is in BUSY
//   last       : BUSY with cnt == 0, i.e. the final execute cycle
module multicycle_timer
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] lat,
    output logic             busy,
    output logic             last
);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The trigger cycle is the first execute cycle and the cnt==0 BUSY cycle
    // is the last, so BUSY is entered with LAT-2 remaining.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = lat - CNT_W'(2);
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    assign last = busy && (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 4-stage pipeline.
// Watches operand-fetch (D) and execute (E) and drives hold/bubble/flush
// controls for the PC and the IF/OF, OF/EX and EX/MEM latches.
// Inputs : validD, rs1D, rs2D, useRs1D, useRs2D, validE, rdE, isWbE, isLdE,
//          isMulE, isDivE, isModE, branchTakenE
// Outputs: stallPC, stallFD, stallDE, flushFD, bubbleDE, bubbleEM,
//          stall (cause code), busyE
// Optional: define HAZ_STATS_EN to add the saturating 16-bit counters
//          stallCycles (cycles with stallPC) and flushCount (cycles with flushFD).
// Parameters: MUL_LAT / DIV_LAT, total execute cycles (1..15).
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validD,
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic             validE,
    input  logic [REG_W-1:0] rdE,
    input  logic             isWbE,
    input  logic             isLdE,
    input  logic             isMulE,
    input  logic             isDivE,
    input  logic             isModE,
    input  logic             branchTakenE,
    output logic             stallPC,
    output logic             stallFD,
    output logic             stallDE,
    output logic             flushFD,
    output logic             bubbleDE,
    output logic             bubbleEM,
    output logic [1:0]       stall,
    output logic             busyE
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]      stallCycles,
    output logic [15:0]      flushCount
`endif
);

    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);

    logic             is_multi;
    logic [CNT_W-1:0] lat_sel;
    logic             trigger;
    logic             busy;
    logic             last;
    logic             multi_hold;
    logic             load_use;

    // MUL takes precedence if the decoder ever flags more than one kind.
    assign is_multi = validE && (isMulE || isDivE || isModE);
    assign lat_sel  = isMulE ? MUL_LAT_C : DIV_LAT_C;
    assign trigger  = is_multi && !busy && (lat_sel > CNT_W'(1));

    multicycle_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .start (trigger),
        .lat   (lat_sel),
        .busy  (busy),
        .last  (last)
    );

    // Front end is held from the trigger cycle through the cycle before last.
    assign multi_hold = trigger || (busy && !last);

    // Load-use compare, one comparator per source operand; r0 is a real register.
    logic [REG_W-1:0] src_reg [2];
    logic [1:0]       src_use;
    logic [1:0]       src_hit;

    assign src_reg[0] = rs1D;
    assign src_reg[1] = rs2D;
    assign src_use    = {useRs2D, useRs1D};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_hit[gi] = src_use[gi] && (src_reg[gi] == rdE);
        end
    endgenerate

    assign load_use = validE && isLdE && isWbE && validD && (|src_hit);

    // Output priority: multi-cycle, then (suppressed while BUSY) branch, load-use.
    always_comb begin
        stallPC  = 1'b0;
        stallFD  = 1'b0;
        stallDE  = 1'b0;
        flushFD  = 1'b0;
        bubbleDE = 1'b0;
        bubbleEM = 1'b0;
        stall    = STALL_NONE;
        if (multi_hold) begin
            stallPC  = 1'b1;
            stallFD  = 1'b1;
            stallDE  = 1'b1;
            bubbleEM = 1'b1;
            stall    = STALL_MULTI;
        end else if (busy) begin
            // final execute cycle: result leaves, nothing is held
        end else if (validE && branchTakenE) begin
            flushFD  = 1'b1;
            bubbleDE = 1'b1;
            stall    = STALL_FLUSH;
        end else if (load_use) begin
            stallPC  = 1'b1;
            stallFD  = 1'b1;
            bubbleDE = 1'b1;
            stall    = STALL_LDUSE;
        end
    end

    assign busyE = busy;

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stallPC && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (flushFD && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    assign stallCycles = stall_cycles_q;
    assign flushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Two instances share inputs:
// u_dut (MUL_LAT=3, DIV_LAT=8) and u_dut1 (MUL_LAT=1, DIV_LAT=8).
// Observed outputs packed as {busyE, stall[1:0], stallPC, stallFD, stallDE,
// flushFD, bubbleDE, bubbleEM}.
module tb_pipeline_hazard_ctrl;

    localparam logic [8:0] NONE  = 9'b0_00_000_000;
    localparam logic [8:0] M0    = 9'b0_10_111_001;  // trigger cycle
    localparam logic [8:0] MB    = 9'b1_10_111_001;  // BUSY, still holding
    localparam logic [8:0] LAST  = 9'b1_00_000_000;  // BUSY, final cycle
    localparam logic [8:0] LDU   = 9'b0_01_110_010;
    localparam logic [8:0] BR    = 9'b0_11_000_110;

    logic       clk = 1'b0;
    logic       reset;
    logic       validD, useRs1D, useRs2D, validE;
    logic [3:0] rs1D, rs2D, rdE;
    logic       isWbE, isLdE, isMulE, isDivE, isModE, branchTakenE;

    logic       stallPC, stallFD, stallDE, flushFD, bubbleDE, bubbleEM, busyE;
    logic [1:0] stall;
    logic       o1_stallPC, o1_stallFD, o1_stallDE, o1_flushFD, o1_bubbleDE, o1_bubbleEM, o1_busyE;
    logic [1:0] o1_stall;
`ifdef HAZ_STATS_EN
    logic [15:0] stallCycles, flushCount, o1_stallCycles, o1_flushCount;
`endif

    int errors = 0;
    int checks = 0;
    int exp_stall_cycles = 0;
    int exp_flush_count = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(8)) u_dut (
        .clk(clk), .reset(reset),
        .validD(validD), .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .validE(validE), .rdE(rdE), .isWbE(isWbE), .isLdE(isLdE),
        .isMulE(isMulE), .isDivE(isDivE), .isModE(isModE), .branchTakenE(branchTakenE),
        .stallPC(stallPC), .stallFD(stallFD), .stallDE(stallDE), .flushFD(flushFD),
        .bubbleDE(bubbleDE), .bubbleEM(bubbleEM), .stall(stall), .busyE(busyE)
`ifdef HAZ_STATS_EN
        , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
    );

    pipeline_hazard_ctrl #(.MUL_LAT(1), .DIV_LAT(8)) u_dut1 (
        .clk(clk), .reset(reset),
        .validD(validD), .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .validE(validE), .rdE(rdE), .isWbE(isWbE), .isLdE(isLdE),
        .isMulE(isMulE), .isDivE(isDivE), .isModE(isModE), .branchTakenE(branchTakenE),
        .stallPC(o1_stallPC), .stallFD(o1_stallFD), .stallDE(o1_stallDE), .flushFD(o1_flushFD),
        .bubbleDE(o1_bubbleDE), .bubbleEM(o1_bubbleEM), .stall(o1_stall), .busyE(o1_busyE)
`ifdef HAZ_STATS_EN
        , .stallCycles(o1_stallCycles), .flushCount(o1_flushCount)
`endif
    );

    wire [8:0] obs0 = {busyE, stall, stallPC, stallFD, stallDE, flushFD, bubbleDE, bubbleEM};
    wire [8:0] obs1 = {o1_busyE, o1_stall, o1_stallPC, o1_stallFD, o1_stallDE,
                       o1_flushFD, o1_bubbleDE, o1_bubbleEM};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic clr_in();
        validD = 0; rs1D = 0; rs2D = 0; useRs1D = 0; useRs2D = 0;
        validE = 0; rdE = 0; isWbE = 0; isLdE = 0;
        isMulE = 0; isDivE = 0; isModE = 0; branchTakenE = 0;
    endtask

    // Start a new cycle: wait for the falling edge and clear all inputs.
    task automatic nxt();
        @(negedge clk);
        clr_in();
    endtask

    // Check u_dut's outputs for this cycle and advance the statistics model.
    task automatic cyc(input string tag, input logic [8:0] exp);
        #1;
        check(tag, {23'd0, obs0}, {23'd0, exp});
        if (exp[5]) exp_stall_cycles++;
        if (exp[2]) exp_flush_count++;
    endtask

    task automatic lu(input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2,
                      input logic u1, input logic u2);
        validE = 1; isLdE = 1; isWbE = 1; rdE = rd;
        validD = 1; rs1D = r1; rs2D = r2; useRs1D = u1; useRs2D = u2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        exp_stall_cycles = 0;
        exp_flush_count = 0;

        nxt(); cyc("reset_idle", NONE);
        check("reset_idle_dut1", {23'd0, obs1}, {23'd0, NONE});

        // DIV (LAT=8) with reset asserted in the 4th BUSY cycle
        nxt(); validE = 1; isDivE = 1; cyc("div_trigger", M0);
        for (int i = 1; i <= 4; i++) begin
            nxt(); validE = 1; isDivE = 1;
            if (i == 4) reset = 1;
            cyc($sformatf("div_busy%0d", i), MB);
        end
        nxt(); reset = 0;
        exp_stall_cycles = 0;
        exp_flush_count = 0;
        cyc("div_post_reset", NONE);

        // MUL, LAT=3 on u_dut; LAT=1 on u_dut1 never stalls
        for (int i = 0; i < 3; i++) begin
            nxt(); validE = 1; isMulE = 1;
            cyc($sformatf("mul_c%0d", i), (i == 0) ? M0 : ((i == 1) ? MB : LAST));
            check($sformatf("mul_lat1_c%0d", i), {23'd0, obs1}, {23'd0, NONE});
        end
        nxt(); cyc("mul_done", NONE);

        // Back-to-back MUL: two separate windows of two stall cycles each
        for (int i = 0; i < 6; i++) begin
            nxt(); validE = 1; isMulE = 1;
            cyc($sformatf("mul2_c%0d", i), ((i % 3) == 0) ? M0 : (((i % 3) == 1) ? MB : LAST));
        end
        nxt(); cyc("mul2_done", NONE);

        // Load-use
        nxt(); lu(4'd5, 4'd3, 4'd5, 1'b1, 1'b1); cyc("lu_rs2", LDU);
        nxt(); validD = 1; rs2D = 5; useRs2D = 1; cyc("lu_bubble_in_e", NONE);
        nxt(); lu(4'd5, 4'd3, 4'd5, 1'b1, 1'b0); cyc("lu_rs2_unused", NONE);
        nxt(); lu(4'd0, 4'd0, 4'd9, 1'b1, 1'b0); cyc("lu_rs1_r0", LDU);
        nxt(); lu(4'd15, 4'd15, 4'd1, 1'b1, 1'b1); cyc("lu_rs1_r15", LDU);
        nxt(); lu(4'd15, 4'd14, 4'd13, 1'b1, 1'b1); cyc("lu_no_match", NONE);
        nxt(); lu(4'd6, 4'd6, 4'd0, 1'b1, 1'b0); isWbE = 0; cyc("lu_no_wb", NONE);
        nxt(); lu(4'd6, 4'd6, 4'd0, 1'b1, 1'b0); validD = 0; cyc("lu_no_validd", NONE);

        // Branch outranks load-use
        nxt(); lu(4'd5, 4'd5, 4'd0, 1'b1, 1'b0); branchTakenE = 1; cyc("br_over_lu", BR);
        nxt(); cyc("br_done", NONE);

        // Multi-cycle outranks branch; BUSY suppresses it; load-use right after
        nxt(); validE = 1; isMulE = 1; branchTakenE = 1; cyc("mul_over_br", M0);
        nxt(); validE = 1; isMulE = 1; branchTakenE = 1; cyc("busy_over_br", MB);
        nxt(); validE = 1; isMulE = 1; branchTakenE = 1; cyc("last_suppress_br", LAST);
        nxt(); lu(4'd7, 4'd7, 4'd0, 1'b1, 1'b0); cyc("lu_after_busy", LDU);
        nxt(); cyc("final_idle", NONE);

`ifdef HAZ_STATS_EN
        @(negedge clk);
        check("stall_cycles", {16'd0, stallCycles}, exp_stall_cycles);
        check("flush_count", {16'd0, flushCount}, exp_flush_count);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 4-stage pipeline (fetch, operand-fetch, execute, memory/writeback). It watches the operand-fetch and execute stages and drives the hold, bubble and flush controls for the PC and for the IF/OF, OF/EX and EX/MEM latches. It resolves three conditions: load-use hazards, multi-cycle MUL/DIV/MOD occupancy of the execute stage, and taken-branch flushes. It also produces the 2-bit `stall` code consumed by the pipeline latches.

## Interface
Parameters:
- MUL_LAT, 3, total cycles a MUL occupies execute; legal range 1..15.
- DIV_LAT, 8, total cycles a DIV/MOD occupies execute; legal range 1..15.

Ports (`name  direction  width  meaning`):
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- validD  in  1  operand-fetch stage holds a real instruction.
- rs1D, rs2D  in  4 each  source register numbers in operand-fetch.
- useRs1D, useRs2D  in  1 each  the corresponding source is actually read.
- validE  in  1  execute stage holds a real instruction.
- rdE  in  4  destination register number in execute.
- isWbE, isLdE  in  1 each  execute instruction writes back / is a load.
- isMulE, isDivE, isModE  in  1 each  execute instruction is multi-cycle.
- branchTakenE  in  1  execute resolved a taken branch, call, return or unconditional branch.
- stallPC  out  1  hold the PC.
- stallFD  out  1  hold the IF/OF latch.
- stallDE  out  1  hold the OF/EX latch.
- flushFD  out  1  load a NOP into the IF/OF latch.
- bubbleDE  out  1  load a NOP into the OF/EX latch.
- bubbleEM  out  1  load a NOP into the EX/MEM latch.
- stall  out  2  cause code: 00 none, 01 load-use, 10 multi-cycle, 11 branch flush.
- busyE  out  1  FSM is in BUSY.

## Operation
- Registered state: FSM {IDLE, BUSY} and a 4-bit down-counter `cnt`. All outputs are combinational from this state and the current-cycle inputs, so the latches act on them in the same cycle.
- **Multi-cycle op:** LAT is MUL_LAT for isMulE and DIV_LAT for isDivE|isModE.
  - Trigger: IDLE with validE & (isMulE|isDivE|isModE) and LAT>1. Assert stallPC, stallFD, stallDE and bubbleEM. Load cnt=LAT-2 and go to BUSY.
  - BUSY with cnt!=0: hold all of those outputs and decrement cnt.
  - BUSY with cnt==0: deassert everything and go to IDLE. The result enters EX/MEM on this edge.
  - LAT==1: no stall is generated.
- **Load-use:** condition is validE & isLdE & isWbE & validD & ((useRs1D & rs1D==rdE) | (useRs2D & rs2D==rdE)).
  - Response: assert stallPC, stallFD and bubbleDE for exactly one cycle; stall=01.
  - All 16 registers are compared; none is hardwired.
- **Branch:** validE & branchTakenE asserts flushFD and bubbleDE for one cycle; stall=11. No hold signals are asserted.
- **Priority**, highest first: BUSY/trigger (stall=10), then branch, then load-use. Detection of the lower-priority causes is suppressed while BUSY.
- Branches and multi-cycle ops are mutually exclusive in execute. If both inputs are asserted, the multi-cycle path wins.
- When no condition holds, all outputs are 0.
- Reset: state=IDLE, cnt=0, and all registered outputs clear. Reset during BUSY abandons the operation; the cycle after reset deasserts shows no stall.

## Timing
- Multi-cycle op: occupies execute for exactly LAT cycles and stalls the front end LAT-1 cycles. bubbleEM is high for LAT-1 cycles.
- Load-use: one bubble; the dependent instruction enters execute one cycle late.
- Branch: zero-cycle reaction. The two younger instructions are killed in the resolving cycle.
- A load-use check on the instruction following a multi-cycle op runs normally in the cycle after BUSY exits.

## Configuration
- `HAZ_STATS_EN` defined: adds outputs stallCycles[15:0] and flushCount[15:0].
  - stallCycles increments each cycle that stallPC=1; flushCount increments each cycle that flushFD=1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- `HAZ_STATS_EN` undefined: these ports and counters are absent. Control behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the FSM state enum;
  - the stall cause constants STALL_NONE, STALL_LDUSE, STALL_MULTI and STALL_FLUSH;
  - the register-index width (4).
- Sub-module `multicycle_timer` holds the IDLE/BUSY FSM and cnt, and exports busy and last. The hazard comparison and output priority stay in the top level.

## Test plan
- MUL in execute, MUL_LAT=3 -> stallPC/stallFD/stallDE/bubbleEM high for 2 cycles, stall=10, then all low.
- LD r5 in execute and ADD using rs2D=5 with useRs2D=1 -> one cycle of stallPC/stallFD/bubbleDE, stall=01. Repeat with useRs2D=0 -> no stall.
- branchTakenE=1 with a load-use hazard also present -> flushFD=bubbleDE=1, stall=11, stallPC=0.
- DIV with DIV_LAT=8, reset asserted in the 4th BUSY cycle -> next cycle IDLE, all outputs 0, busyE=0.
- MUL_LAT=1 -> no stall. Back-to-back MUL, MUL -> two separate stall windows of LAT-1 cycles each.
- With `HAZ_STATS_EN` defined, run the above sequence -> stallCycles equals the summed stallPC cycles and flushCount=1.
